// File: rtl/can_encoder.sv
// can_encoder
//   CAN 2.0A/B frame transmitter. A request (identifier, IDE, RTR, DLC, payload)
//   is latched on start and serialised onto tx_bit as SOF, arbitration, control,
//   data, CRC-15, CRC delimiter, ACK slot, ACK delimiter, EOF and intermission.
//   Stuff bits are inserted from SOF through the last CRC bit. Every bit change
//   happens on the falling edge of sample_point, so a receiver sampling on the
//   rising edge sees a stable value.
//
// Parameters
//   CRC_POLY      CRC-15 generator polynomial (x^15 implicit)
//   EOF_BITS      recessive end-of-frame bits
//   IFS_BITS      recessive intermission bits
// Ports
//   clock         system clock, all logic on posedge
//   reset         synchronous active-high reset
//   sample_point  bit-time strobe; a bit advances on its falling edge
//   start         frame request, accepted only while busy==0
//   in_id_a       11-bit base identifier
//   in_ide        1 = extended frame
//   in_rtr        1 = remote frame (no data field)
//   in_id_b       18-bit extended identifier (unused for standard frames)
//   in_dlc        data length code (9..15 send 8 bytes)
//   in_data       payload, byte 0 in [63:56], sent MSB first
//   tx_bit        bus bit, 0 = dominant
//   busy          high from acceptance until the last intermission bit ends
//   done          one-clock pulse when the last intermission bit ends
//   stuff_active  current tx_bit is a stuff bit
module can_encoder #(
  parameter logic [14:0] CRC_POLY = 15'h4599,
  parameter int unsigned EOF_BITS = 7,
  parameter int unsigned IFS_BITS = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sample_point,
  input  logic        start,
  input  logic [10:0] in_id_a,
  input  logic        in_ide,
  input  logic        in_rtr,
  input  logic [17:0] in_id_b,
  input  logic [3:0]  in_dlc,
  input  logic [63:0] in_data,
  output logic        tx_bit,
  output logic        busy,
  output logic        done,
  output logic        stuff_active
);

  // Order matters: stuffing covers S_SOF..S_CRC, CRC accumulation S_SOF..S_DATA.
  typedef enum logic [4:0] {
    S_IDLE, S_SOF, S_ID_A, S_RTR_SRR, S_IDE, S_ID_B, S_RTR_EXT, S_R1, S_R0,
    S_DLC, S_DATA, S_CRC, S_CRC_DEL, S_ACK_SLOT, S_ACK_DEL, S_EOF, S_IFS
  } state_t;

  // r_state/r_cnt name the field and bit index currently on tx_bit
  state_t      r_state, w_state_nxt, w_adv_state;
  logic [6:0]  r_cnt, w_cnt_nxt, w_adv_cnt;
  logic        r_sp_q;
  logic        w_tick;

  logic [10:0] r_id_a;
  logic        r_ide;
  logic        r_rtr;
  logic [17:0] r_id_b;
  logic [3:0]  r_dlc;
  logic [63:0] r_data;

  logic [14:0] r_crc, w_crc_nxt;
  logic        r_last, w_last_nxt;
  logic [2:0]  r_run, w_run_nxt;
  logic        r_tx, w_tx_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_done, w_done_nxt;
  logic        r_stuff, w_stuff_nxt;

  logic [6:0]  w_data_len;
  logic        w_adv_bit;
  logic        w_in_stuff_zone;
  logic [3:0]  w_ida_idx;
  logic [4:0]  w_idb_idx;
  logic [1:0]  w_dlc_idx;
  logic [5:0]  w_dat_idx;
  logic [3:0]  w_crc_idx;

  assign w_tick          = r_sp_q & ~sample_point;
  assign w_data_len      = r_rtr    ? 7'd0 :
                           r_dlc[3] ? 7'd64 : {1'b0, r_dlc[2:0], 3'b000};
  assign w_in_stuff_zone = (r_state >= S_SOF) && (r_state <= S_CRC);

  assign w_ida_idx = 4'd10 - w_adv_cnt[3:0];
  assign w_idb_idx = 5'd17 - w_adv_cnt[4:0];
  assign w_dlc_idx = 2'd3  - w_adv_cnt[1:0];
  assign w_dat_idx = 6'd63 - w_adv_cnt[5:0];
  assign w_crc_idx = 4'd14 - w_adv_cnt[3:0];

  // Successor of the current (field, index) in the frame sequence
  always_comb begin
    w_adv_state = r_state;
    w_adv_cnt   = '0;
    case (r_state)
      S_IDLE:    w_adv_state = S_SOF;
      S_SOF:     w_adv_state = S_ID_A;
      S_ID_A:    if (r_cnt == 7'd10) w_adv_state = S_RTR_SRR;
                 else                w_adv_cnt   = r_cnt + 7'd1;
      S_RTR_SRR: w_adv_state = S_IDE;
      S_IDE:     w_adv_state = r_ide ? S_ID_B : S_R0;
      S_ID_B:    if (r_cnt == 7'd17) w_adv_state = S_RTR_EXT;
                 else                w_adv_cnt   = r_cnt + 7'd1;
      S_RTR_EXT: w_adv_state = S_R1;
      S_R1:      w_adv_state = S_R0;
      S_R0:      w_adv_state = S_DLC;
      S_DLC:     if (r_cnt == 7'd3) w_adv_state = (w_data_len == 7'd0) ? S_CRC : S_DATA;
                 else               w_adv_cnt   = r_cnt + 7'd1;
      S_DATA:    if (r_cnt == w_data_len - 7'd1) w_adv_state = S_CRC;
                 else                            w_adv_cnt   = r_cnt + 7'd1;
      S_CRC:     if (r_cnt == 7'd14) w_adv_state = S_CRC_DEL;
                 else                w_adv_cnt   = r_cnt + 7'd1;
      S_CRC_DEL: w_adv_state = S_ACK_SLOT;
      S_ACK_SLOT: w_adv_state = S_ACK_DEL;
      S_ACK_DEL: w_adv_state = S_EOF;
      S_EOF:     if (r_cnt == 7'(EOF_BITS - 1)) w_adv_state = S_IFS;
                 else                           w_adv_cnt   = r_cnt + 7'd1;
      S_IFS:     if (r_cnt == 7'(IFS_BITS - 1)) w_adv_state = S_IDLE;
                 else                           w_adv_cnt   = r_cnt + 7'd1;
      default:   w_adv_state = S_IDLE;
    endcase
  end

  // Value of the successor bit; SRR is recessive in extended frames
  always_comb begin
    w_adv_bit = 1'b1;
    case (w_adv_state)
      S_SOF:     w_adv_bit = 1'b0;
      S_ID_A:    w_adv_bit = r_id_a[w_ida_idx];
      S_RTR_SRR: w_adv_bit = r_ide | r_rtr;
      S_IDE:     w_adv_bit = r_ide;
      S_ID_B:    w_adv_bit = r_id_b[w_idb_idx];
      S_RTR_EXT: w_adv_bit = r_rtr;
      S_R1:      w_adv_bit = 1'b0;
      S_R0:      w_adv_bit = 1'b0;
      S_DLC:     w_adv_bit = r_dlc[w_dlc_idx];
      S_DATA:    w_adv_bit = r_data[w_dat_idx];
      S_CRC:     w_adv_bit = r_crc[w_crc_idx];
      default:   w_adv_bit = 1'b1;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_crc_nxt   = r_crc;
    w_last_nxt  = r_last;
    w_run_nxt   = r_run;
    w_tx_nxt    = r_tx;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_stuff_nxt = r_stuff;
    if (!r_busy) begin
      if (start) w_busy_nxt = 1'b1;
    end else if (w_tick) begin
      if (w_in_stuff_zone && (r_run == 3'd5)) begin
        // Field position holds; the stuff bit starts a new run of one
        w_tx_nxt    = ~r_last;
        w_last_nxt  = ~r_last;
        w_run_nxt   = 3'd1;
        w_stuff_nxt = 1'b1;
      end else begin
        w_stuff_nxt = 1'b0;
        w_state_nxt = w_adv_state;
        w_cnt_nxt   = w_adv_cnt;
        w_tx_nxt    = w_adv_bit;
        if (w_adv_state == S_IDLE) begin
          w_busy_nxt = 1'b0;
          w_done_nxt = 1'b1;
        end
        if (w_adv_state == S_SOF) begin
          // SOF is dominant, so clearing then shifting it in leaves zero
          w_crc_nxt  = '0;
          w_run_nxt  = 3'd1;
          w_last_nxt = 1'b0;
        end else if ((w_adv_state > S_SOF) && (w_adv_state <= S_CRC)) begin
          w_run_nxt  = (w_adv_bit == r_last) ? r_run + 3'd1 : 3'd1;
          w_last_nxt = w_adv_bit;
        end
        if ((w_adv_state > S_SOF) && (w_adv_state <= S_DATA)) begin
          w_crc_nxt = {r_crc[13:0], 1'b0} ^
                      ((w_adv_bit ^ r_crc[14]) ? CRC_POLY : 15'h0);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sp_q  <= 1'b0;
      r_crc   <= '0;
      r_last  <= 1'b0;
      r_run   <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_stuff <= 1'b0;
      r_id_a  <= '0;
      r_ide   <= 1'b0;
      r_rtr   <= 1'b0;
      r_id_b  <= '0;
      r_dlc   <= '0;
      r_data  <= '0;
    end else begin
      r_sp_q  <= sample_point;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_crc   <= w_crc_nxt;
      r_last  <= w_last_nxt;
      r_run   <= w_run_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_stuff <= w_stuff_nxt;
      if (!r_busy && start) begin
        r_id_a <= in_id_a;
        r_ide  <= in_ide;
        r_rtr  <= in_rtr;
        r_id_b <= in_id_b;
        r_dlc  <= in_dlc;
        r_data <= in_data;
      end
    end
  end

  assign tx_bit       = r_tx;
  assign busy         = r_busy;
  assign done         = r_done;
  assign stuff_active = r_stuff;

endmodule
